hsv_core_commit_multi: RTL
==========================

Name: hsv_core_commit_multi

Overview:
- Parametrised in-order commit stage for the hsv_core back end; sits after the NUM_UNITS execution-unit output channels and feeds regfile writeback, issue scoreboard and the core controller.
- Retires exactly one instruction per cycle, the one whose token matches the commit token.
- Over the previous fixed five-unit commit it adds:
  - arbitrary unit count;
  - an explicit RUN/HALT state machine that blocks commits during flush and IRQ entry;
  - multi-match detection;
  - a retired-instruction counter;
  - a programmable reset PC.

Parameters:
NUM_UNITS, 5, number of execution-unit input channels (>=1)
RETIRE_W, 64, width of retired-instruction counter
RESET_PC, 32'h0000_0000, value of ctrl_next_pc after reset

Ports:
clk_core  in  1  core clock
rst_core_n  in  1  asynchronous active-low reset
flush_target  in  word  PC loaded when flush handshake completes
flush_req  in  1  controller flush request (level)
flush_ack  out  1  registered copy of flush_req
unit_data  in  commit_data_t[NUM_UNITS]  per-unit result/action/token
unit_valid_i  in  NUM_UNITS  per-unit valid
unit_ready_o  out  NUM_UNITS  per-unit ready (token match, RUN only)
unit_commit_o  out  NUM_UNITS  per-unit commit strobe (non-trapping retire)
ctrl_flush_begin  out  1  combinational: selected entry requests flush
ctrl_trap  out  1  registered trap pulse
ctrl_trap_cause  out  exception_t  registered cause
ctrl_trap_value  out  word  registered tval
ctrl_mode_return  out  1  registered xRET pulse
ctrl_wait_irq  out  1  registered WFI pulse
ctrl_next_pc  out  word  PC after last retired instruction
ctrl_commit  out  1  any unit_commit_o
ctrl_begin_irq  in  1  controller taking interrupt this cycle
wr_addr  out  reg_addr  writeback address
wr_data  out  word  writeback data
wr_en  out  1  writeback enable
token  out  insn_token  current commit token
commit_mask  out  reg_mask  scoreboard release mask
retired  out  RETIRE_W  retired-instruction count
err_multi  out  1  sticky: >1 unit committable in one cycle

Behaviour:
- Reset (async, rst_core_n low):
  - Outputs and state: token=0, state=RUN, flush_ack=1, ctrl_next_pc=RESET_PC, retired=0, err_multi=0, all registered ctrl_* =0.
  - Combinational outputs follow the reset state.
- unit_ready_o[i] = (state==RUN) & !ctrl_begin_irq & (unit_data[i].common.token==token).
- committable[i] = unit_ready_o[i] & unit_valid_i[i].
- Selection: lowest committable index is used_data; none → used_data='0. More than one committable sets err_multi (sticky until reset).
- unit_commit_o[i] = committable[i] & (i==selected) & !unit_data[i].trap; ctrl_commit = OR of these.
- Writeback, same cycle as selection:
  - wr_en = used_data.writeback & !action.trap;
  - wr_addr/wr_data from used_data;
  - commit_mask = action.trap ? '0 : rd_mask.
- ctrl_flush_begin = action.flush of used_data (0 when nothing selected).
- Registered outputs (one cycle after selection): ctrl_trap, cause, value, mode_return, wait_irq. Each is 0 when nothing was selected.
- Token: +1 (wraps at insn_token width) on ctrl_commit & !action.flush.
- retired: +1 on ctrl_commit (wraps); never cleared by flush.
- ctrl_next_pc <= used_data.next_pc on ctrl_commit.
- flush_ack <= flush_req every cycle. token_clear = flush_ack & !flush_req.
- FSM:
  - RUN→HALT on any of: a selected entry with action.flush or action.trap; ctrl_begin_irq; flush_req=1. The flushing instruction itself still retires/increments retired.
  - HALT: no ready, no commit, token held.
  - HALT→RUN on token_clear: token<=0, ctrl_next_pc<=flush_target.
  - token_clear in RUN (post-reset handshake): same token/pc update, stay RUN.
  - token_clear has priority over increment in the same cycle.
- Reset mid-flush returns to RUN with flush_ack=1; the next cycle with flush_req=0 triggers token_clear.

Decomposition:
- hsv_core_pkg already holds commit_data_t, commit_action_bits_t, insn_token, word, reg_addr, reg_mask, exception_t. Add commit_state_t {COMMIT_RUN, COMMIT_HALT} there.
- One sub-module: hsv_core_commit_select. Parametric lowest-index one-hot selector over NUM_UNITS, returning sel index, any, and multi flags.

Test Plan:
- Reset, flush_req=0 → cycle 1 token_clear: token=0, ctrl_next_pc=flush_target, state RUN.
- NUM_UNITS=5; units 2,0,4 present tokens 0,1,2 in that order, each valid one cycle → unit_commit_o = 00100, 00001, 10000 on consecutive cycles; wr_en each cycle; retired=3; token=3.
- Unit 1 token match, trap=1, cause=2 → unit_commit_o=0, wr_en=0, commit_mask=0; next cycle ctrl_trap=1, ctrl_trap_cause=2; state HALT; ready low until flush_req 1→0; then token=0, ctrl_next_pc=flush_target.
- Entry with action.flush=1, next_pc=0x100 → ctrl_flush_begin=1 same cycle; retired+1; token unchanged; HALT until handshake.
- Units 0 and 3 both valid with matching token → unit 0 commits, err_multi=1 and stays 1.
- ctrl_begin_irq=1 with matching valid entry → no commit, token held, state HALT.

Source files
------------

// File: rtl/hsv_core_pkg.sv
// rtl/hsv_core_pkg.sv - shared hsv_core back-end types, including the commit-stage state encoding
package hsv_core_pkg;

   typedef logic [31:0] word;
   typedef logic [7:0]  insn_token;
   typedef logic [4:0]  reg_addr;
   typedef logic [31:0] reg_mask;

   typedef enum logic [3:0] {
      EXC_INSN_MISALIGN = 4'd0,
      EXC_INSN_FAULT    = 4'd1,
      EXC_ILLEGAL_INSN  = 4'd2,
      EXC_BREAKPOINT    = 4'd3,
      EXC_LOAD_FAULT    = 4'd5,
      EXC_ECALL         = 4'd11
   } exception_t;

   typedef struct packed {
      logic trap;
      logic flush;
      logic mode_return;
      logic wait_irq;
   } commit_action_bits_t;

   typedef struct packed {
      insn_token token;
      word       pc;
   } commit_common_t;

   typedef struct packed {
      commit_common_t      common;
      commit_action_bits_t action;
      logic                writeback;
      reg_addr             rd;
      reg_mask             rd_mask;
      word                 result;
      word                 next_pc;
      exception_t          trap_cause;
      word                 trap_value;
   } commit_data_t;

   typedef enum logic {
      COMMIT_RUN,
      COMMIT_HALT
   } commit_state_t;

endpackage

// File: rtl/hsv_core_commit_select.sv
// rtl/hsv_core_commit_select.sv - lowest-index priority selector with any/multi flags
module hsv_core_commit_select #(
   parameter int N  = 5,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   output logic [IW-1:0] sel_o,
   output logic          any_o,
   output logic          multi_o
);

   // Descending scan so the lowest requesting index is the last one written.
   always_comb begin
      sel_o = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) sel_o = IW'(i);
      end
   end

   assign any_o   = |req_i;
   assign multi_o = |(req_i & (req_i - N'(1)));

endmodule

// File: rtl/hsv_core_commit_multi.sv
// rtl/hsv_core_commit_multi.sv - in-order commit stage over NUM_UNITS execution channels
module hsv_core_commit_multi
   import hsv_core_pkg::*;
#(
   parameter int  NUM_UNITS = 5,
   parameter int  RETIRE_W  = 64,
   parameter word RESET_PC  = 32'h0000_0000
) (
   input  logic                 clk_core,
   input  logic                 rst_core_n,
   input  word                  flush_target,
   input  logic                 flush_req,
   output logic                 flush_ack,
   input  commit_data_t         unit_data [NUM_UNITS],
   input  logic [NUM_UNITS-1:0] unit_valid_i,
   output logic [NUM_UNITS-1:0] unit_ready_o,
   output logic [NUM_UNITS-1:0] unit_commit_o,
   output logic                 ctrl_flush_begin,
   output logic                 ctrl_trap,
   output exception_t           ctrl_trap_cause,
   output word                  ctrl_trap_value,
   output logic                 ctrl_mode_return,
   output logic                 ctrl_wait_irq,
   output word                  ctrl_next_pc,
   output logic                 ctrl_commit,
   input  logic                 ctrl_begin_irq,
   output reg_addr              wr_addr,
   output word                  wr_data,
   output logic                 wr_en,
   output insn_token            token,
   output reg_mask              commit_mask,
   output logic [RETIRE_W-1:0]  retired,
   output logic                 err_multi
);

   localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   commit_state_t         state_q;
   insn_token             token_q;
   word                   next_pc_q;
   logic [RETIRE_W-1:0]   retired_q;
   logic                  err_multi_q;
   logic                  flush_ack_q;
   logic                  trap_q;
   exception_t            cause_q;
   word                   tval_q;
   logic                  mode_return_q;
   logic                  wait_irq_q;

   logic [NUM_UNITS-1:0]  committable;
   logic [IW-1:0]         sel;
   logic                  any;
   logic                  multi;
   commit_data_t          used_data;
   logic                  token_clear;
   logic                  halt_req;

   always_comb begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         unit_ready_o[i] = (state_q == COMMIT_RUN) & ~ctrl_begin_irq
                         & (unit_data[i].common.token == token_q);
      end
   end

   assign committable = unit_ready_o & unit_valid_i;

   hsv_core_commit_select #(.N(NUM_UNITS), .IW(IW)) u_select (
      .req_i   (committable),
      .sel_o   (sel),
      .any_o   (any),
      .multi_o (multi)
   );

   assign used_data = any ? unit_data[sel] : '0;

   // A trapping entry is consumed by the selector but never strobes a commit.
   always_comb begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         unit_commit_o[i] = committable[i] & (sel == IW'(i)) & ~unit_data[i].action.trap;
      end
   end

   assign ctrl_commit      = |unit_commit_o;
   assign ctrl_flush_begin = used_data.action.flush;
   assign wr_en            = used_data.writeback & ~used_data.action.trap;
   assign wr_addr          = used_data.rd;
   assign wr_data          = used_data.result;
   assign commit_mask      = used_data.action.trap ? '0 : used_data.rd_mask;

   assign token_clear = flush_ack_q & ~flush_req;
   assign halt_req    = (any & (used_data.action.flush | used_data.action.trap))
                      | ctrl_begin_irq | flush_req;

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         state_q       <= COMMIT_RUN;
         token_q       <= '0;
         next_pc_q     <= RESET_PC;
         retired_q     <= '0;
         err_multi_q   <= 1'b0;
         flush_ack_q   <= 1'b1;
         trap_q        <= 1'b0;
         cause_q       <= exception_t'('0);
         tval_q        <= '0;
         mode_return_q <= 1'b0;
         wait_irq_q    <= 1'b0;
      end else begin
         flush_ack_q   <= flush_req;
         trap_q        <= used_data.action.trap;
         cause_q       <= used_data.trap_cause;
         tval_q        <= used_data.trap_value;
         mode_return_q <= used_data.action.mode_return;
         wait_irq_q    <= used_data.action.wait_irq;
         if (multi) err_multi_q <= 1'b1;
         if (ctrl_commit) retired_q <= retired_q + RETIRE_W'(1);
         if (token_clear) begin
            token_q   <= '0;
            next_pc_q <= flush_target;
         end else if (ctrl_commit) begin
            next_pc_q <= used_data.next_pc;
            if (!used_data.action.flush) token_q <= token_q + insn_token'(1);
         end
         case (state_q)
            COMMIT_RUN:  if (halt_req) state_q <= COMMIT_HALT;
            COMMIT_HALT: if (token_clear) state_q <= COMMIT_RUN;
            default:     state_q <= COMMIT_RUN;
         endcase
      end
   end

   assign flush_ack        = flush_ack_q;
   assign token            = token_q;
   assign ctrl_next_pc     = next_pc_q;
   assign retired          = retired_q;
   assign err_multi        = err_multi_q;
   assign ctrl_trap        = trap_q;
   assign ctrl_trap_cause  = cause_q;
   assign ctrl_trap_value  = tval_q;
   assign ctrl_mode_return = mode_return_q;
   assign ctrl_wait_irq    = wait_irq_q;

endmodule
